cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port of the mp3 core between the instruction cache and the data cache.
- Sits between the two caches' line-level miss interfaces and the cacheline adapter that drives the mp3 `burst_o`/`burst_i`/`address_o`/`read_o`/`write_o`/`resp_i` ports.
- Grants one outstanding line transaction at a time, with round-robin fairness.
- Raises a sticky error if memory fails to respond within a bounded number of cycles.

Parameters:
- LINE_W, 256, cache line width in bits.
- ADDR_W, 32, address width in bits.
- TIMEOUT, 1023, maximum cycles a granted transaction may wait for resp_i before err_o sets; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_read  in  1  icache line-fill request.
- i_address  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to the icache.
- i_resp  out  1  icache transaction complete.
- d_read  in  1  dcache line-fill request.
- d_write  in  1  dcache writeback request.
- d_address  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache writeback line.
- d_rdata  out  LINE_W  line returned to the dcache.
- d_resp  out  1  dcache transaction complete.
- mem_read  out  1  read request to the cacheline adapter.
- mem_write  out  1  write request to the cacheline adapter.
- mem_address  out  ADDR_W  address to the adapter.
- mem_wdata  out  LINE_W  write line to the adapter.
- mem_rdata  in  LINE_W  line from the adapter.
- mem_resp  in  1  adapter transaction complete.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last_grant=DCACHE, timer=0, err_o=0.
  - All outputs 0 while in reset, including mem_read, mem_write, i_resp, d_resp, mem_address, mem_wdata.
  - Reset mid-transaction drops the transaction immediately; no response is issued.
- States:
  - IDLE: no memory request asserted; i_resp=d_resp=0.
  - I_BUSY: mem_read=1, mem_address=i_address.
  - D_RD: mem_read=1, mem_address=d_address.
  - D_WR: mem_write=1, mem_address=d_address, mem_wdata=d_wdata.
- mem_* outputs are decoded from the registered state only. They never depend combinationally on request inputs.
- IDLE transitions, sampled at the clock edge:
  - If only icache requests, go to I_BUSY.
  - If only dcache requests, go to D_WR if d_write else D_RD.
  - d_write has precedence if d_read and d_write are both high.
  - If both caches request, grant the one not equal to last_grant: last_grant=DCACHE grants icache, last_grant=ICACHE grants dcache.
  - last_grant updates on entry to a busy state.
- Busy transitions:
  - While in a busy state and mem_resp=1: assert the owner's resp for exactly that cycle and return to IDLE.
  - i_rdata/d_rdata carry mem_rdata continuously; they are valid to the owner when its resp=1.
  - The non-owner's resp stays 0.
- Latency: request high in cycle N (IDLE) gives mem request high from cycle N+1. Owner resp equals mem_resp in the same cycle.
- Gap: at least one IDLE cycle separates consecutive transactions. A request still high in that IDLE cycle is re-arbitrated normally.
- Request inputs are ignored while busy. The owner must hold its request and address stable until its resp.
- Timer:
  - Clears on entry to a busy state and increments each busy cycle without mem_resp.
  - When timer reaches TIMEOUT, err_o sets and remains set until reset. The state stays busy (no abort).
  - The timer saturates and does not wrap.
- mem_resp in IDLE is ignored and produces no cache resp.

Test Plan:
- Icache only: i_read=1 and i_address=0x0000_0060 in cycle 0.
  - Required: mem_read=1 with mem_address=0x60 from cycle 1.
  - Drive mem_resp=1 in cycle 5 with mem_rdata=0xA5 repeated: i_resp=1 only in cycle 5, i_rdata matches, state IDLE in cycle 6.
- Dcache writeback: d_write=1, d_address=0x1000, d_wdata=0xDEAD… pattern.
  - Required: mem_write=1 with matching address and data from cycle 1; d_resp pulses with mem_resp; i_resp stays 0.
- Simultaneous requests after reset (last_grant=DCACHE): i_read and d_read both held high.
  - Required: icache is serviced first, then after one IDLE cycle dcache; a third simultaneous round goes to icache again.
- Dcache with d_read=1 and d_write=1 together.
  - Required: D_WR entered, mem_write=1, mem_read=0.
- Timeout with TIMEOUT=8: grant icache, never assert mem_resp.
  - Required: err_o=1 after 8 busy cycles, stays 1 after a later mem_resp completes the transaction.
- Reset mid-operation: rst=0 during D_RD.
  - Required: mem_read and d_resp are 0 immediately (asynchronously); after release, IDLE with err_o=0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Round-robin sharing of one line-level memory port between the
//            icache and dcache, with a sticky response-timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_RD   = 2'd2,
        D_WR   = 2'd3
    } state_t;

    localparam int              TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);

    state_t          state_q, state_d;
    logic            last_i_q, last_i_d;   // 1: icache held the most recent grant
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            d_req;
    logic            d_owner;

    assign d_req   = d_read | d_write;
    assign d_owner = (state_q == D_RD) || (state_q == D_WR);

    always_comb begin
        state_d  = state_q;
        last_i_d = last_i_q;
        timer_d  = timer_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                // On contention the cache that did not win last time goes first.
                if (i_read && (!d_req || !last_i_q)) begin
                    state_d  = I_BUSY;
                    last_i_d = 1'b1;
                    timer_d  = '0;
                end else if (d_req) begin
                    state_d  = d_write ? D_WR : D_RD;
                    last_i_d = 1'b0;
                    timer_d  = '0;
                end
            end
            default: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end else if (timer_q != TMAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
        if (timer_d == TMAX) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_i_q <= 1'b0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_i_q <= last_i_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    assign mem_read    = (state_q == I_BUSY) || (state_q == D_RD);
    assign mem_write   = (state_q == D_WR);
    assign mem_address = (state_q == I_BUSY) ? i_address :
                         d_owner             ? d_address : '0;
    assign mem_wdata   = (state_q == D_WR) ? d_wdata : '0;

    assign i_resp  = (state_q == I_BUSY) && mem_resp;
    assign d_resp  = d_owner && mem_resp;
    // Read data is a pass-through, forced low only while reset is held.
    assign i_rdata = rst ? mem_rdata : '0;
    assign d_rdata = rst ? mem_rdata : '0;
    assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Directed self-checking bench for cache_mem_arbiter (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              err_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [LINE_W-1:0] pat_a5;
    logic [LINE_W-1:0] pat_dead;
    logic [LINE_W-1:0] pat_rd;

    cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        pat_a5   = {32{8'hA5}};
        pat_dead = {8{32'hDEADBEEF}};
        pat_rd   = {16{16'h1234}};
        rst = 1'b0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; mem_rdata = pat_a5; mem_resp = 0;
        tick(); tick();
        // Everything low while reset is held, including the read-data pass-through.
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b1;
        tick();

        // Contention right after reset: icache first, then dcache, then icache.
        i_read = 1; i_address = 32'h200; d_read = 1; d_address = 32'h300;
        tick();
        chk("rr1_read", mem_read, 1);
        chk("rr1_addr", mem_address, 32'h200);
        mem_resp = 1; #1;
        chk("rr1_iresp", i_resp, 1);
        chk("rr1_dresp", d_resp, 0);
        tick(); mem_resp = 0; #1;
        chk("rr_gap_idle", mem_read, 0);
        tick();
        chk("rr2_addr", mem_address, 32'h300);
        mem_resp = 1; #1;
        chk("rr2_dresp", d_resp, 1);
        chk("rr2_iresp", i_resp, 0);
        tick(); mem_resp = 0; #1;
        tick();
        chk("rr3_addr", mem_address, 32'h200);
        chk("rr3_read", mem_read, 1);
        mem_resp = 1; i_read = 0; d_read = 0; #1;
        chk("rr3_iresp", i_resp, 1);
        tick(); mem_resp = 0; #1;

        // Icache only.
        i_read = 1; i_address = 32'h0000_0060; #1;
        chk("ic_not_comb", mem_read, 0);
        tick();
        chk("ic_read", mem_read, 1);
        chk("ic_addr", mem_address, 32'h60);
        chk("ic_resp_early", i_resp, 0);
        tick(); tick(); tick(); tick();
        mem_resp = 1; mem_rdata = pat_a5; i_read = 0; #1;
        chk("ic_resp", i_resp, 1);
        chk("ic_rdata", i_rdata, pat_a5);
        chk("ic_dresp", d_resp, 0);
        tick(); mem_resp = 0; #1;
        chk("ic_idle", mem_read, 0);
        chk("ic_resp_off", i_resp, 0);

        // Dcache writeback.
        d_write = 1; d_address = 32'h1000; d_wdata = pat_dead;
        tick();
        chk("dw_write", mem_write, 1);
        chk("dw_read", mem_read, 0);
        chk("dw_addr", mem_address, 32'h1000);
        chk("dw_wdata", mem_wdata, pat_dead);
        tick();
        mem_resp = 1; d_write = 0; #1;
        chk("dw_dresp", d_resp, 1);
        chk("dw_iresp", i_resp, 0);
        tick(); mem_resp = 0; #1;
        chk("dw_idle", mem_write, 0);

        // Read and write together: writeback wins.
        d_read = 1; d_write = 1; d_address = 32'h2040;
        tick();
        chk("drw_write", mem_write, 1);
        chk("drw_read", mem_read, 0);
        mem_resp = 1; d_read = 0; d_write = 0; #1;
        chk("drw_dresp", d_resp, 1);
        tick(); mem_resp = 0; #1;

        // Stray memory response while idle.
        mem_resp = 1; #1;
        chk("idle_iresp", i_resp, 0);
        chk("idle_dresp", d_resp, 0);
        tick(); mem_resp = 0; #1;
        chk("idle_stays", mem_read, 0);

        // Timeout: 8 busy cycles without a response.
        i_read = 1; i_address = 32'h4000;
        tick();
        chk("to_read", mem_read, 1);
        for (int k = 0; k < 7; k++) tick();
        chk("to_err_before", err_o, 0);
        tick();
        chk("to_err_set", err_o, 1);
        chk("to_still_busy", mem_read, 1);
        tick(); tick();
        mem_resp = 1; i_read = 0; #1;
        chk("to_iresp", i_resp, 1);
        tick(); mem_resp = 0; #1;
        chk("to_idle", mem_read, 0);
        tick();
        chk("to_err_sticky", err_o, 1);

        // Asynchronous reset in the middle of a dcache read.
        d_read = 1; d_address = 32'h5000; mem_rdata = pat_rd;
        tick();
        chk("rm_read", mem_read, 1);
        chk("rm_addr", mem_address, 32'h5000);
        #2 rst = 1'b0; mem_resp = 1; #1;
        chk("rm_read_off", mem_read, 0);
        chk("rm_dresp", d_resp, 0);
        chk("rm_err", err_o, 0);
        chk("rm_drdata", d_rdata, 0);
        d_read = 0; mem_resp = 0;
        tick(); rst = 1'b1;
        tick();
        chk("rm_idle", mem_read, 0);
        chk("rm_err_after", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
